// File: rtl/sha3_bus_ctrl.sv
// Bus-side controller for the SHA3 sponge: gathers word writes into a rate block,
// hands full blocks to the absorb core and serves digest words back over the bus.
module sha3_bus_ctrl #(
    parameter int unsigned BITS       = 32,
    parameter int unsigned RATE_WORDS = 18,
    parameter int unsigned OUT_WORDS  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid,
    input  logic [3:0]                 addr,
    input  logic                       we,
    input  logic [3:0]                 wstrb,
    input  logic [BITS-1:0]            wdata,
    input  logic [BITS-1:0]            la_write,
    input  logic [BITS-1:0]            la_input,
    output logic                       ready,
    output logic [BITS-1:0]            rdata,
    output logic [BITS-1:0]            hash_o,
    output logic                       core_start,
    output logic [RATE_WORDS*BITS-1:0] core_block,
    input  logic                       core_done,
    input  logic [RATE_WORDS*BITS-1:0] core_digest
);

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned BUF_AW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
    localparam int unsigned NBYTES = BITS / 8;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ABSORB  = 2'd1,
        SQUEEZE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [BITS-1:0]  buffer [RATE_WORDS];
    logic [BITS-1:0]  digest [RATE_WORDS];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             overflow;
    logic             last_flag;
    logic             start_pend;

    logic            accept;
    logic            sel_ctrl;
    logic            sel_data;
    logic            sel_digest;
    logic            start_req;
    logic            clear_all;
    logic            buf_zero;
    logic            wr_word;
    logic            ovf_set;
    logic            last_set;
    logic            last_clr;
    logic            dig_load;
    logic            rd_adv;
    logic            rd_rst;
    logic            wr_rst;
    logic [BITS-1:0] wmask;
    logic [BITS-1:0] status;
    logic [BITS-1:0] rd_val;

    assign accept     = valid && !ready;
    assign sel_ctrl   = (addr == 4'h0);
    assign sel_data   = (addr == 4'h4);
    assign sel_digest = (addr == 4'h8);

    for (genvar b = 0; b < NBYTES; b++) begin : g_mask
        assign wmask[b*8 +: 8] = {8{wstrb[b % 4]}};
    end

    for (genvar i = 0; i < RATE_WORDS; i++) begin : g_block
        assign core_block[i*BITS +: BITS] = buffer[i];
    end

    always_comb begin
        status        = '0;
        status[4:0]   = wr_idx[4:0];
        status[6:5]   = state;
        status[7]     = overflow;
        status[8]     = last_flag;
        status[13:9]  = rd_idx[4:0];
    end

    // Read mux; only digest reads in SQUEEZE and STATUS return non-zero data
    always_comb begin
        rd_val = '0;
        if (!we) begin
            if (sel_ctrl) begin
                rd_val = status;
            end else if (sel_digest && state == SQUEEZE) begin
                rd_val = digest[rd_idx[BUF_AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Core completion first, then the bus request, so both can act in one cycle
    always_comb begin
        state_next = state;
        start_req  = 1'b0;
        clear_all  = 1'b0;
        buf_zero   = 1'b0;
        wr_word    = 1'b0;
        ovf_set    = 1'b0;
        last_set   = 1'b0;
        last_clr   = 1'b0;
        dig_load   = 1'b0;
        rd_adv     = 1'b0;
        rd_rst     = 1'b0;
        wr_rst     = 1'b0;

        if (state == ABSORB && core_done) begin
            dig_load = 1'b1;
            if (last_flag) begin
                state_next = SQUEEZE;
                rd_rst     = 1'b1;
            end else begin
                state_next = FILL;
                wr_rst     = 1'b1;
                buf_zero   = 1'b1;
            end
        end

        if (accept && we && sel_ctrl) begin
            if (wdata[2]) begin
                state_next = FILL;
                clear_all  = 1'b1;
            end
            if (state == FILL) begin
                if (wdata[1]) begin
                    last_set = 1'b1;
                end
                if (wdata[0]) begin
                    state_next = ABSORB;
                    start_req  = 1'b1;
                end
            end
        end

        if (accept && we && sel_data) begin
            if (state == FILL) begin
                wr_word = 1'b1;
                if (wr_idx == IDX_W'(RATE_WORDS - 1)) begin
                    state_next = ABSORB;
                    start_req  = 1'b1;
                end
            end else begin
                ovf_set = 1'b1;
            end
        end

        if (accept && !we && sel_digest && state == SQUEEZE) begin
            rd_adv = 1'b1;
            if (rd_idx == IDX_W'(OUT_WORDS - 1)) begin
                state_next = FILL;
                last_clr   = 1'b1;
                wr_rst     = 1'b1;
                buf_zero   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RATE_WORDS; i++) begin
                buffer[i] <= '0;
                digest[i] <= '0;
            end
            wr_idx     <= '0;
            rd_idx     <= '0;
            overflow   <= 1'b0;
            last_flag  <= 1'b0;
            start_pend <= 1'b0;
            ready      <= 1'b0;
            rdata      <= '0;
            hash_o     <= '0;
            core_start <= 1'b0;
        end else begin
            if (clear_all || buf_zero) begin
                for (int i = 0; i < RATE_WORDS; i++) begin
                    buffer[i] <= '0;
                end
            end else if (wr_word) begin
                buffer[wr_idx[BUF_AW-1:0]] <= (buffer[wr_idx[BUF_AW-1:0]] & ~wmask)
                                            | (wdata & wmask);
            end

            if (dig_load) begin
                for (int i = 0; i < RATE_WORDS; i++) begin
                    digest[i] <= core_digest[i*BITS +: BITS];
                end
            end

            if (clear_all || wr_rst) begin
                wr_idx <= '0;
            end else if (wr_word) begin
                wr_idx <= wr_idx + IDX_W'(1);
            end

            if (clear_all || rd_rst) begin
                rd_idx <= '0;
            end else if (rd_adv) begin
                rd_idx <= rd_idx + IDX_W'(1);
            end

            if (clear_all) begin
                overflow <= 1'b0;
            end else if (ovf_set) begin
                overflow <= 1'b1;
            end

            if (last_clr) begin
                last_flag <= 1'b0;
            end else if (last_set) begin
                last_flag <= 1'b1;
            end

            // core_start trails the accepting edge by one cycle (one cycle after ready)
            start_pend <= start_req;
            core_start <= start_pend;
            ready      <= accept;
            rdata      <= accept ? rd_val : '0;

            if (rd_adv) begin
                hash_o <= digest[rd_idx[BUF_AW-1:0]];
            end else if (!accept && (|la_write)) begin
                hash_o <= la_write & la_input;
            end
        end
    end

endmodule

// File: tb/tb_sha3_bus_ctrl.sv
// Directed plus randomized bench for sha3_bus_ctrl against a transaction-level
// model of the block buffer, digest pointer and status fields.
module tb_sha3_bus_ctrl;

    localparam int unsigned BITS = 32;
    localparam int unsigned R    = 18;
    localparam int unsigned O    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid;
    logic [3:0]        addr;
    logic              we;
    logic [3:0]        wstrb;
    logic [BITS-1:0]   wdata;
    logic [BITS-1:0]   la_write;
    logic [BITS-1:0]   la_input;
    logic              ready;
    logic [BITS-1:0]   rdata;
    logic [BITS-1:0]   hash_o;
    logic              core_start;
    logic [R*BITS-1:0] core_block;
    logic              core_done;
    logic [R*BITS-1:0] core_digest;

    sha3_bus_ctrl #(.BITS(BITS), .RATE_WORDS(R), .OUT_WORDS(O)) dut (
        .clk(clk), .reset(reset), .valid(valid), .addr(addr), .we(we),
        .wstrb(wstrb), .wdata(wdata), .la_write(la_write), .la_input(la_input),
        .ready(ready), .rdata(rdata), .hash_o(hash_o), .core_start(core_start),
        .core_block(core_block), .core_done(core_done), .core_digest(core_digest)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: message-level view of the controller
    logic [31:0] m_buf [R];
    logic [31:0] m_dig [R];
    logic [31:0] snap  [R];
    int          m_wr, m_rd, m_st;
    logic        m_ovf, m_last;
    logic [31:0] m_hash;
    time         ack_time;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] blk_word(input int i);
        return core_block[i*32 +: 32];
    endfunction

    task automatic m_zero_buf();
        for (int i = 0; i < R; i++) m_buf[i] = '0;
    endtask

    task automatic m_reset();
        m_zero_buf();
        for (int i = 0; i < R; i++) m_dig[i] = '0;
        m_wr = 0; m_rd = 0; m_st = 0;
        m_ovf = 1'b0; m_last = 1'b0; m_hash = '0;
    endtask

    function automatic logic [31:0] m_status();
        return 32'(m_wr & 31) | (32'(m_st) << 5) | (32'(m_ovf) << 7)
             | (32'(m_last) << 8) | (32'(m_rd & 31) << 9);
    endfunction

    task automatic m_data(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) if (s[b]) mask[b*8 +: 8] = 8'hFF;
        if (m_st == 0) begin
            m_buf[m_wr] = d & mask;
            m_wr++;
            if (m_wr == R) m_st = 1;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic m_ctrl(input logic [31:0] v);
        bit infill;
        infill = (m_st == 0);
        if (v[2]) begin
            m_st = 0; m_wr = 0; m_rd = 0; m_ovf = 1'b0;
            m_zero_buf();
        end
        if (infill) begin
            if (v[1]) m_last = 1'b1;
            if (v[0]) m_st = 1;
        end
    endtask

    task automatic m_done();
        if (m_last) begin
            m_st = 2; m_rd = 0;
        end else begin
            m_st = 0; m_wr = 0;
            m_zero_buf();
        end
    endtask

    task automatic m_dread(output logic [31:0] exp);
        exp = '0;
        if (m_st == 2) begin
            exp = m_dig[m_rd];
            m_hash = exp;
            m_rd++;
            if (m_rd == O) begin
                m_st = 0; m_last = 1'b0; m_wr = 0;
                m_zero_buf();
            end
        end
    endtask

    // One bus request; waits (bounded) for the acknowledge and samples it
    task automatic bus(input logic [3:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] rd, output logic [31:0] hs);
        int n;
        @(negedge clk);
        valid = 1'b1; addr = a; we = w; wstrb = s; wdata = d;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ready && n < 8);
        chk("ack", 32'(ready), 32'd1);
        ack_time = $time;
        rd = rdata;
        hs = hash_o;
        valid = 1'b0;
    endtask

    task automatic write_data(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd, hs;
        bus(4'h4, 1'b1, s, d, rd, hs);
        m_data(d, s);
        chk("wr_rdata", rd, 32'd0);
    endtask

    task automatic ctrl(input logic [31:0] v);
        logic [31:0] rd, hs;
        bus(4'h0, 1'b1, 4'hF, v, rd, hs);
        m_ctrl(v);
    endtask

    task automatic check_status(input string tag);
        logic [31:0] rd, hs;
        bus(4'h0, 1'b0, 4'h0, 32'd0, rd, hs);
        chk(tag, rd, m_status());
        chk({tag, "_hash"}, hs, m_hash);
    endtask

    task automatic read_digest(input string tag);
        logic [31:0] rd, hs, exp;
        bus(4'h8, 1'b0, 4'h0, 32'd0, rd, hs);
        m_dread(exp);
        chk(tag, rd, exp);
        chk({tag, "_hash"}, hs, m_hash);
    endtask

    task automatic chk_block(input string tag);
        for (int i = 0; i < R; i++) chk($sformatf("%s_w%0d", tag, i), blk_word(i), m_buf[i]);
    endtask

    // Expects core_start exactly one cycle after the last acknowledge, as a single pulse
    task automatic wait_start();
        int n;
        n = 0;
        while (!core_start && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk("start_seen", 32'(core_start), 32'd1);
        chk("start_lat", 32'($time - ack_time), 32'd10);
        chk("start_state", 32'(m_st), 32'd1);
        for (int i = 0; i < R; i++) snap[i] = blk_word(i);
        chk_block("start_blk");
        @(posedge clk); #1;
        chk("start_pulse", 32'(core_start), 32'd0);
    endtask

    task automatic do_done(input int delay);
        repeat (delay) @(posedge clk);
        for (int i = 0; i < R; i++) chk($sformatf("stable_w%0d", i), blk_word(i), snap[i]);
        @(negedge clk);
        for (int i = 0; i < R; i++) core_digest[i*32 +: 32] = m_dig[i];
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        m_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        bit          lst;
        logic [31:0] rd, hs;

        reset = 1'b1; valid = 1'b0; addr = '0; we = 1'b0; wstrb = '0; wdata = '0;
        la_write = '0; la_input = '0; core_done = 1'b0; core_digest = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_hash", hash_o, 32'd0);
        chk("rst_start", 32'(core_start), 32'd0);
        chk_block("rst_blk");
        @(negedge clk);
        reset = 1'b0;
        check_status("rst_status");

        // Full block of 1..18
        for (int i = 0; i < R; i++) write_data(32'(i + 1), 4'hF);
        wait_start();
        chk("full_w0", blk_word(0), 32'h1);
        chk("full_w17", blk_word(17), 32'h12);
        check_status("full_status");
        chk("full_state", m_status(), 32'h32);
        for (int i = 0; i < R; i++) m_dig[i] = $urandom;
        do_done(3);
        check_status("full_after");
        chk_block("full_zeroed");

        // Strobe merge, then a partial last block
        write_data(32'hAABBCCDD, 4'b0101);
        chk("strobe", blk_word(0), 32'h00BB00DD);
        for (int i = 0; i < 4; i++) write_data($urandom, 4'($urandom_range(0, 15)));
        ctrl(32'h3);
        wait_start();

        // Overflow while absorbing
        write_data(32'hDEADBEEF, 4'hF);
        check_status("ovf_status");
        chk("ovf_value", m_status(), 32'h1A5);
        chk_block("ovf_blk");
        for (int i = 0; i < R; i++) m_dig[i] = 32'h100 + 32'(i);
        do_done(24);
        check_status("sq_status");
        for (int j = 0; j < O; j++) begin
            if (j == 3) begin
                la_write = 32'hFFFF0000;
                la_input = 32'h12345678;
            end
            read_digest($sformatf("dig%0d", j));
            la_write = '0;
            chk($sformatf("dig%0d_const", j), hash_o, 32'h100 + 32'(j));
        end
        check_status("sq_after");
        chk("sq_after_value", m_status(), 32'h2080);
        read_digest("dig_idle");
        ctrl(32'h4);
        check_status("clear_status");

        // Reserved and wrong-direction accesses have no side effect
        bus(4'hC, 1'b0, 4'h0, 32'd0, rd, hs);
        chk("rsv_rd", rd, 32'd0);
        bus(4'hC, 1'b1, 4'hF, 32'hFFFFFFFF, rd, hs);
        bus(4'h8, 1'b1, 4'hF, 32'hFFFFFFFF, rd, hs);
        chk("dig_wr", rd, 32'd0);
        bus(4'h4, 1'b0, 4'h0, 32'd0, rd, hs);
        chk("data_rd", rd, 32'd0);
        check_status("noeffect_status");

        // Logic-analyser passthrough while idle
        @(negedge clk);
        la_write = 32'hFFFF0000;
        la_input = 32'h12345678;
        @(posedge clk); #1;
        chk("la_hash", hash_o, 32'h12340000);
        la_write = '0;
        m_hash = 32'h12340000;

        // Randomized messages
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, R);
            lst = 1'($urandom_range(0, 1));
            if (it == 0) n = 0;
            if (it == 1) begin n = R; lst = 1'b1; end
            if (lst && n == R) ctrl(32'h2);
            for (int k = 0; k < n; k++) write_data($urandom, 4'($urandom_range(0, 15)));
            if (n < R) ctrl({29'd0, 1'b0, lst, 1'b1});
            wait_start();
            check_status("rnd_absorb");
            for (int i = 0; i < R; i++) m_dig[i] = $urandom;
            do_done($urandom_range(1, 30));
            check_status("rnd_done");
            chk_block("rnd_blk");
            if (lst) begin
                for (int j = 0; j < O; j++) read_digest($sformatf("rnd_dig%0d", j));
                check_status("rnd_sq_end");
            end
        end

        // Reset in the middle of an absorb, then a stray core_done
        write_data(32'h0BADF00D, 4'hF);
        ctrl(32'h1);
        wait_start();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        core_digest = {R{32'hCAFEF00D}};
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        @(posedge clk); #1;
        chk("mid_ready", 32'(ready), 32'd0);
        chk("mid_start", 32'(core_start), 32'd0);
        chk("mid_hash", hash_o, 32'd0);
        check_status("mid_status");
        chk_block("mid_blk");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
